// File: rtl/calc_pkg.sv
// Shared key codes, entry-state and operator encodings for the keypad
// expression capture path.
package calc_pkg;

   localparam int KEY_ZERO  = 10;
   localparam int KEY_ADD   = 11;
   localparam int KEY_SUB   = 12;
   localparam int KEY_MUL   = 13;
   localparam int KEY_DIV   = 14;
   localparam int KEY_ENTER = 15;
   localparam int KEY_CLEAR = 16;
   localparam int KEY_BKSP  = 17;

   typedef enum logic [2:0] {
      ST_A      = 3'b000,
      ST_OP     = 3'b001,
      ST_B      = 3'b010,
      ST_RESULT = 3'b011,
      ST_ERR    = 3'b100
   } entry_state_t;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2,
      OP_DIV = 2'd3
   } op_t;

endpackage

// File: rtl/bcd_entry_reg.sv
// Right-justified BCD operand shift register with digit count.
// Push-when-full is never requested; the owning FSM rejects that case.
module bcd_entry_reg
   import calc_pkg::*;
#(
   parameter int unsigned DIGITS = 2
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             clr,
   input  logic                             load,
   input  logic                             push,
   input  logic                             pop,
   input  logic [3:0]                       din,
   output logic [4*DIGITS-1:0]              value,
   output logic [$clog2(DIGITS+1)-1:0]      count,
   output logic                             full,
   output logic                             empty
);

   localparam int unsigned W     = 4 * DIGITS;
   localparam int unsigned CNT_W = $clog2(DIGITS + 1);

   logic [W-1:0]     value_q, value_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      value_d = value_q;
      count_d = count_q;
      if (clr) begin
         value_d = '0;
         count_d = '0;
      end else if (load) begin
         value_d = W'(din);
         count_d = CNT_W'(1);
      end else if (push) begin
         value_d = (value_q << 4) | W'(din);
         count_d = count_q + CNT_W'(1);
      end else if (pop) begin
         value_d = value_q >> 4;
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         value_q <= '0;
         count_q <= '0;
      end else begin
         value_q <= value_d;
         count_q <= count_d;
      end
   end

   assign value = value_q;
   assign count = count_q;
   assign full  = (count_q == CNT_W'(DIGITS));
   assign empty = (count_q == '0);

endmodule

// File: rtl/expr_entry_fsm.sv
// Keypad expression capture: operand A, operator, operand B, then a
// req/ack handoff to the ALU with divide-by-zero trap.
module expr_entry_fsm
   import calc_pkg::*;
#(
   parameter int unsigned DIGITS = 2,
   parameter int unsigned KEY_W  = 5
) (
   input  logic                          clk_manual_verify,
   input  logic                          reset_n,
   input  logic                          key_valid,
   input  logic [KEY_W-1:0]              key_code,
   input  logic                          calc_ack,
   output logic [4*DIGITS-1:0]           operand_a,
   output logic [4*DIGITS-1:0]           operand_b,
   output logic [1:0]                    op_code,
   output logic [2:0]                    state,
   output logic [$clog2(DIGITS+1)-1:0]   a_cnt,
   output logic [$clog2(DIGITS+1)-1:0]   b_cnt,
   output logic                          calc_req,
   output logic                          key_reject,
   output logic                          div_zero
);

   localparam logic [KEY_W-1:0] K_ZERO  = KEY_W'(KEY_ZERO);
   localparam logic [KEY_W-1:0] K_ADD   = KEY_W'(KEY_ADD);
   localparam logic [KEY_W-1:0] K_SUB   = KEY_W'(KEY_SUB);
   localparam logic [KEY_W-1:0] K_MUL   = KEY_W'(KEY_MUL);
   localparam logic [KEY_W-1:0] K_DIV   = KEY_W'(KEY_DIV);
   localparam logic [KEY_W-1:0] K_ENTER = KEY_W'(KEY_ENTER);
   localparam logic [KEY_W-1:0] K_CLEAR = KEY_W'(KEY_CLEAR);
   localparam logic [KEY_W-1:0] K_BKSP  = KEY_W'(KEY_BKSP);

   entry_state_t state_q, state_d;
   op_t          op_q, op_d;
   logic         req_q, req_d;
   logic         rej_q, rej_d;
   logic         dz_q, dz_d;

   logic         is_digit, is_op, is_enter, is_clear, is_bksp, key_known;
   logic [3:0]   digit_val;
   op_t          key_op;

   logic         a_clr, a_load, a_push, a_pop, a_full, a_empty;
   logic         b_clr, b_load, b_push, b_pop, b_full, b_empty;
   logic [4*DIGITS-1:0]         a_value, b_value;
   logic [$clog2(DIGITS+1)-1:0] a_count, b_count;

   // Key decode
   always_comb begin
      is_digit  = 1'b0;
      is_op     = 1'b0;
      is_enter  = 1'b0;
      is_clear  = 1'b0;
      is_bksp   = 1'b0;
      digit_val = '0;
      key_op    = OP_ADD;
      case (key_code)
         K_ZERO:  is_digit = 1'b1;
         K_ADD:   begin is_op = 1'b1; key_op = OP_ADD; end
         K_SUB:   begin is_op = 1'b1; key_op = OP_SUB; end
         K_MUL:   begin is_op = 1'b1; key_op = OP_MUL; end
         K_DIV:   begin is_op = 1'b1; key_op = OP_DIV; end
         K_ENTER: is_enter = 1'b1;
         K_CLEAR: is_clear = 1'b1;
         K_BKSP:  is_bksp  = 1'b1;
         default: begin
            if (key_code >= KEY_W'(1) && key_code <= KEY_W'(9)) begin
               is_digit  = 1'b1;
               digit_val = key_code[3:0];
            end
         end
      endcase
      key_known = is_digit | is_op | is_enter | is_bksp;
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      req_d   = req_q;
      rej_d   = 1'b0;
      dz_d    = dz_q;
      a_clr   = 1'b0;
      a_load  = 1'b0;
      a_push  = 1'b0;
      a_pop   = 1'b0;
      b_clr   = 1'b0;
      b_load  = 1'b0;
      b_push  = 1'b0;
      b_pop   = 1'b0;

      if (key_valid && is_clear) begin
         state_d = ST_A;
         op_d    = OP_ADD;
         req_d   = 1'b0;
         dz_d    = 1'b0;
         a_clr   = 1'b1;
         b_clr   = 1'b1;
      end else begin
         // Ack is applied before the key so RESULT sees the post-ack view
         if (calc_ack && req_q) req_d = 1'b0;

         if (key_valid) begin
            unique case (state_q)
               ST_A: begin
                  if (is_digit) begin
                     if (a_full) rej_d = 1'b1;
                     else        a_push = 1'b1;
                  end else if (is_op) begin
                     if (a_empty) rej_d = 1'b1;
                     else begin
                        op_d    = key_op;
                        state_d = ST_OP;
                     end
                  end else if (is_bksp) begin
                     if (a_empty) rej_d = 1'b1;
                     else         a_pop = 1'b1;
                  end else if (is_enter) begin
                     rej_d = 1'b1;
                  end
               end
               ST_OP: begin
                  if (is_op) begin
                     op_d = key_op;
                  end else if (is_digit) begin
                     b_load  = 1'b1;
                     state_d = ST_B;
                  end else if (is_bksp) begin
                     op_d    = OP_ADD;
                     state_d = ST_A;
                  end else if (is_enter) begin
                     rej_d = 1'b1;
                  end
               end
               ST_B: begin
                  if (is_digit) begin
                     if (b_full) rej_d = 1'b1;
                     else        b_push = 1'b1;
                  end else if (is_bksp) begin
                     if (b_empty) rej_d = 1'b1;
                     else begin
                        b_pop = 1'b1;
                        if (b_count == $bits(b_count)'(1)) state_d = ST_OP;
                     end
                  end else if (is_op) begin
                     rej_d = 1'b1;
                  end else if (is_enter) begin
                     if (op_q == OP_DIV && b_value == '0) begin
                        state_d = ST_ERR;
                        dz_d    = 1'b1;
                     end else begin
                        state_d = ST_RESULT;
                        req_d   = 1'b1;
                     end
                  end
               end
               ST_RESULT: begin
                  if (req_q && !calc_ack) begin
                     rej_d = key_known;
                  end else if (is_digit) begin
                     a_load  = 1'b1;
                     b_clr   = 1'b1;
                     op_d    = OP_ADD;
                     state_d = ST_A;
                  end else begin
                     rej_d = key_known;
                  end
               end
               ST_ERR: rej_d = key_known;
               default: state_d = ST_A;
            endcase
         end
      end
   end

   always_ff @(posedge clk_manual_verify or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_A;
         op_q    <= OP_ADD;
         req_q   <= 1'b0;
         rej_q   <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         req_q   <= req_d;
         rej_q   <= rej_d;
         dz_q    <= dz_d;
      end
   end

   bcd_entry_reg #(.DIGITS(DIGITS)) u_reg_a (
      .clk     (clk_manual_verify),
      .reset_n (reset_n),
      .clr     (a_clr),
      .load    (a_load),
      .push    (a_push),
      .pop     (a_pop),
      .din     (digit_val),
      .value   (a_value),
      .count   (a_count),
      .full    (a_full),
      .empty   (a_empty)
   );

   bcd_entry_reg #(.DIGITS(DIGITS)) u_reg_b (
      .clk     (clk_manual_verify),
      .reset_n (reset_n),
      .clr     (b_clr),
      .load    (b_load),
      .push    (b_push),
      .pop     (b_pop),
      .din     (digit_val),
      .value   (b_value),
      .count   (b_count),
      .full    (b_full),
      .empty   (b_empty)
   );

   assign operand_a  = a_value;
   assign operand_b  = b_value;
   assign a_cnt      = a_count;
   assign b_cnt      = b_count;
   assign op_code    = op_q;
   assign state      = state_q;
   assign calc_req   = req_q;
   assign key_reject = rej_q;
   assign div_zero   = dz_q;

endmodule

// File: tb/tb_expr_entry_fsm.sv
// Bench for expr_entry_fsm: DIGITS=2 and DIGITS=4 instances share one key
// stream and are compared against an arithmetic reference model.
module tb_expr_entry_fsm;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       key_valid = 1'b0;
   logic       calc_ack = 1'b0;
   logic [4:0] key_code = '0;

   logic [7:0]  a2, b2;
   logic [1:0]  op2, ac2, bc2;
   logic [2:0]  st2;
   logic        req2, rej2, dz2;
   logic [15:0] a4, b4;
   logic [1:0]  op4;
   logic [2:0]  st4, ac4, bc4;
   logic        req4, rej4, dz4;

   int checks = 0;
   int errors = 0;

   int dg[2] = '{2, 4};
   int m_a[2], m_an[2], m_b[2], m_bn[2], m_op[2], m_st[2];
   int m_req[2], m_rej[2], m_dz[2];

   always #5 clk = ~clk;

   expr_entry_fsm #(.DIGITS(2), .KEY_W(5)) dut (
      .clk_manual_verify(clk), .reset_n(reset_n), .key_valid(key_valid),
      .key_code(key_code), .calc_ack(calc_ack), .operand_a(a2), .operand_b(b2),
      .op_code(op2), .state(st2), .a_cnt(ac2), .b_cnt(bc2), .calc_req(req2),
      .key_reject(rej2), .div_zero(dz2));

   expr_entry_fsm #(.DIGITS(4), .KEY_W(5)) dut4 (
      .clk_manual_verify(clk), .reset_n(reset_n), .key_valid(key_valid),
      .key_code(key_code), .calc_ack(calc_ack), .operand_a(a4), .operand_b(b4),
      .op_code(op4), .state(st4), .a_cnt(ac4), .b_cnt(bc4), .calc_req(req4),
      .key_reject(rej4), .div_zero(dz4));

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_a[i] = 0; m_an[i] = 0; m_b[i] = 0; m_bn[i] = 0; m_op[i] = 0;
         m_st[i] = 0; m_req[i] = 0; m_rej[i] = 0; m_dz[i] = 0;
      end
   endfunction

   // States: 0 A, 1 OP, 2 B, 3 RESULT, 4 ERR. Operands kept as BCD integers.
   function automatic void model_step(bit v, int c, bit k);
      bit digit, isop, ent, bk, known;
      int d;
      digit = (c >= 1 && c <= 10);
      d     = (c == 10) ? 0 : c;
      isop  = (c >= 11 && c <= 14);
      ent   = (c == 15);
      bk    = (c == 17);
      known = digit || isop || ent || bk;
      if (v && c == 16) begin
         model_reset();
         return;
      end
      for (int i = 0; i < 2; i++) begin
         m_rej[i] = 0;
         if (k && m_req[i] != 0) m_req[i] = 0;
         if (!v) continue;
         case (m_st[i])
            0: begin
               if (digit) begin
                  if (m_an[i] == dg[i]) m_rej[i] = 1;
                  else begin m_a[i] = m_a[i] * 16 + d; m_an[i]++; end
               end else if (isop) begin
                  if (m_an[i] == 0) m_rej[i] = 1;
                  else begin m_op[i] = c - 11; m_st[i] = 1; end
               end else if (bk) begin
                  if (m_an[i] == 0) m_rej[i] = 1;
                  else begin m_a[i] = m_a[i] / 16; m_an[i]--; end
               end else if (ent) m_rej[i] = 1;
            end
            1: begin
               if (isop) m_op[i] = c - 11;
               else if (digit) begin m_b[i] = d; m_bn[i] = 1; m_st[i] = 2; end
               else if (bk) begin m_op[i] = 0; m_st[i] = 0; end
               else if (ent) m_rej[i] = 1;
            end
            2: begin
               if (digit) begin
                  if (m_bn[i] == dg[i]) m_rej[i] = 1;
                  else begin m_b[i] = m_b[i] * 16 + d; m_bn[i]++; end
               end else if (bk) begin
                  m_b[i] = m_b[i] / 16; m_bn[i]--;
                  if (m_bn[i] == 0) m_st[i] = 1;
               end else if (isop) m_rej[i] = 1;
               else if (ent) begin
                  if (m_op[i] == 3 && m_b[i] == 0) begin m_st[i] = 4; m_dz[i] = 1; end
                  else begin m_st[i] = 3; m_req[i] = 1; end
               end
            end
            3: begin
               if (m_req[i] != 0) m_rej[i] = known;
               else if (digit) begin
                  m_a[i] = d; m_an[i] = 1; m_b[i] = 0; m_bn[i] = 0;
                  m_op[i] = 0; m_st[i] = 0;
               end else m_rej[i] = known;
            end
            default: m_rej[i] = known;
         endcase
      end
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("d2.operand_a", 32'(a2),   m_a[0]);
      chk("d2.operand_b", 32'(b2),   m_b[0]);
      chk("d2.op_code",   32'(op2),  m_op[0]);
      chk("d2.state",     32'(st2),  m_st[0]);
      chk("d2.a_cnt",     32'(ac2),  m_an[0]);
      chk("d2.b_cnt",     32'(bc2),  m_bn[0]);
      chk("d2.calc_req",  32'(req2), m_req[0]);
      chk("d2.key_reject",32'(rej2), m_rej[0]);
      chk("d2.div_zero",  32'(dz2),  m_dz[0]);
      chk("d4.operand_a", 32'(a4),   m_a[1]);
      chk("d4.operand_b", 32'(b4),   m_b[1]);
      chk("d4.op_code",   32'(op4),  m_op[1]);
      chk("d4.state",     32'(st4),  m_st[1]);
      chk("d4.a_cnt",     32'(ac4),  m_an[1]);
      chk("d4.b_cnt",     32'(bc4),  m_bn[1]);
      chk("d4.calc_req",  32'(req4), m_req[1]);
      chk("d4.key_reject",32'(rej4), m_rej[1]);
      chk("d4.div_zero",  32'(dz4),  m_dz[1]);
   endtask

   // One clock edge: drive at negedge, update model at posedge, check after.
   task automatic step(bit v, int c, bit k);
      @(negedge clk);
      key_valid = v;
      key_code  = 5'(c);
      calc_ack  = k;
      @(posedge clk);
      model_step(v, c, k);
      #1;
      check_all();
      key_valid = 1'b0;
      calc_ack  = 1'b0;
   endtask

   task automatic key(int c);
      step(1'b1, c, 1'b0);
   endtask

   task automatic async_reset();
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1 check_all();
      @(negedge clk);
      reset_n = 1'b1;

      // T1
      key(1); key(2); key(11); key(3); key(4); key(15);
      chk("T1.a", 32'(a2), 32'h12);
      chk("T1.b", 32'(b2), 32'h34);
      chk("T1.state", 32'(st2), 32'd3);
      chk("T1.req", 32'(req2), 32'd1);
      step(1'b0, 0, 1'b0);
      chk("T1.req_hold", 32'(req2), 32'd1);
      step(1'b0, 0, 1'b1);
      step(1'b0, 0, 1'b0);
      chk("T1.req_drop", 32'(req2), 32'd0);

      // T2
      key(9); key(8);
      chk("T2.a", 32'(a2), 32'h98);
      key(7);
      chk("T2.reject", 32'(rej2), 32'd1);
      chk("T2.a4", 32'(a4), 32'h987);
      key(17);
      chk("T2.bksp", 32'(a2), 32'h09);
      chk("T2.cnt", 32'(ac2), 32'd1);

      // T3
      key(16);
      key(17); key(15); key(11);
      key(5);  chk("T3.s0", 32'(st2), 32'd0);
      key(13); chk("T3.s1", 32'(st2), 32'd1);
      key(17); chk("T3.s2", 32'(st2), 32'd0);
      key(12); chk("T3.s3", 32'(st2), 32'd1);
      key(14); key(12);
      key(6);  chk("T3.s4", 32'(st2), 32'd2);
      chk("T3.op", 32'(op2), 32'd1);
      chk("T3.b", 32'(b2), 32'h06);
      key(11); key(17); key(17); key(7); key(15);
      step(1'b0, 0, 1'b1);

      // T4
      key(16);
      key(4); key(14); key(10); key(10); key(15);
      chk("T4.state", 32'(st2), 32'd4);
      chk("T4.dz", 32'(dz2), 32'd1);
      key(1); key(15); step(1'b0, 0, 1'b1);
      key(16);
      chk("T4.clear", 32'(st2), 32'd0);
      key(7); key(14); key(2); key(15);
      chk("T4.div_ok", 32'(st2), 32'd3);

      // T5
      key(7);
      chk("T5.busy_reject", 32'(rej2), 32'd1);
      step(1'b1, 7, 1'b1);
      chk("T5.req", 32'(req2), 32'd0);
      chk("T5.a", 32'(a2), 32'h07);
      step(1'b0, 0, 1'b1);
      key(11); key(3); key(15);
      step(1'b1, 16, 1'b1);
      key(1); key(15); key(15); step(1'b1, 18, 1'b0); step(1'b1, 0, 1'b0);
      step(1'b1, 31, 1'b0);
      step(1'b0, 0, 1'b1);
      key(19); key(15);

      // T6
      key(16);
      key(1); key(2); key(11); key(3);
      async_reset();
      key(1); key(2); key(11); key(3); key(4); key(15);
      async_reset();
      key(1); key(2); key(11); key(3); key(4); key(15);
      chk("T6.a4", 32'(a4), 32'h0012);
      chk("T6.b4", 32'(b4), 32'h0034);
      step(1'b0, 0, 1'b1);

      for (int n = 0; n < 1500; n++) begin
         step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 20)),
              ($urandom_range(0, 3) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
